// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider (N >= 2) with 50% or single-pulse output.
// Ratio and duty mode change only at a period boundary, so clk_out never glitches.
//
// state | meaning
// IDLE  | stopped, cnt held at 0, clk_out low
// RUN   | dividing, en high
// STOP  | en dropped, finishing the period in progress

module prog_clk_div #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             duty_mode,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             running,
  output logic             tick,
  output logic             clk_out
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, pend_div;
  logic             pend_valid, cur_mode;
  logic             active, wrap, boundary, accept;
  logic             a_pos, a_neg, stretch;

  assign active    = (state != IDLE);
  assign wrap      = active && (cnt == cur_div - ONE);
  assign boundary  = !active || wrap;
  assign cfg_ready = !pend_valid;
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_err   = accept && (cfg_div < MIN_DIV);
  assign running   = active;
  // a_neg only ever extends a_pos by half a cycle, so the OR cannot glitch
  assign clk_out   = a_pos | a_neg;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        if (!en) state_nxt = wrap ? IDLE : STOP;
      end
      STOP: begin
        cnt_nxt = wrap ? '0 : cnt + ONE;
        if (en)        state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_div    <= DEF_DIV;
      cur_mode   <= 1'b0;
      pend_div   <= DEF_DIV;
      pend_valid <= 1'b0;
      tick       <= 1'b0;
      a_pos      <= 1'b0;
      stretch    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tick    <= active && (cnt == '0);
      // (N>>1) is N/2 for even N and (N-1)/2 for odd N; odd ratios get the half-cycle stretch
      a_pos   <= active && (cur_mode ? (cnt == '0) : (cnt < (cur_div >> 1)));
      stretch <= active && !cur_mode && cur_div[0];
      if (boundary) cur_mode <= duty_mode;
      if (boundary && pend_valid) begin
        cur_div    <= pend_div;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_div   <= (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(negedge clk_in) begin
    if (rst) a_neg <= 1'b0;
    else     a_neg <= a_pos && stretch;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: reset, even/odd 50% ratios, mid-period config,
// clean stop/start, clamping, max ratio and reset during pulse mode with pending config.

module tb_prog_clk_div;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, en, duty_mode, cfg_valid;
  logic [CW-1:0] cfg_div;
  logic          cfg_ready, cfg_err, running, tick, clk_out;
  logic [CW-1:0] cur_div;

  int tests = 0;
  int fails = 0;

  prog_clk_div #(.CNT_W(CW), .DEFAULT_DIV(4)) dut (
    .clk_in(clk), .rst(rst), .en(en), .duty_mode(duty_mode),
    .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .cur_div(cur_div), .running(running),
    .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; duty_mode = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (3) step();
    tests++;
    if ({cfg_ready, cfg_err, running, tick, clk_out, cur_div} !== {5'b10000, 8'd4}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h",
               {cfg_ready, cfg_err, running, tick, clk_out, cur_div}, {5'b10000, 8'd4});
    end
    @(negedge clk); #1;
    tests++;
    if (clk_out !== 1'b0) begin
      fails++; $display("FAIL reset_clk_low_phase: got %b expected 0", clk_out);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_even_default();
    logic [7:0] ck, tk;
    en = 1'b1;
    step();
    tests++;
    if ({running, tick, clk_out} !== 3'b100) begin
      fails++; $display("FAIL start_state: got %b expected 100", {running, tick, clk_out});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      ck[i] = clk_out;
      tk[i] = tick;
    end
    tests++;
    if (ck !== 8'h33) begin fails++; $display("FAIL div4_clk: got %h expected 33", ck); end
    tests++;
    if (tk !== 8'h11) begin fails++; $display("FAIL div4_tick: got %h expected 11", tk); end
    tests++;
    if (cur_div !== 8'd4) begin fails++; $display("FAIL div4_cur_div: got %0d expected 4", cur_div); end
  endtask

  // exp_halves: bit 2i = clk_out in the high clk phase of cycle i, bit 2i+1 = low phase
  task automatic test_ratio(input int n, input logic [31:0] exp_halves);
    logic [31:0]   halves;
    logic [CW-1:0] d;
    int            tk_cnt;
    d = n[CW-1:0];
    cfg_div = d; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0) begin fails++; $display("FAIL ratio%0d_ready_low: got %b expected 0", n, cfg_ready); end
    for (int k = 0; k < 40; k++) begin
      if (tick === 1'b1 && cur_div === d) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === d)) begin
      fails++; $display("FAIL ratio%0d_apply: got cur_div %0d tick %b expected %0d and 1", n, cur_div, tick, n);
    end
    halves = '0; tk_cnt = 0;
    for (int i = 0; i < 2 * n; i++) begin
      halves[2*i] = clk_out;
      tk_cnt += int'(tick);
      @(negedge clk); #1;
      halves[2*i+1] = clk_out;
      step();
    end
    tests++;
    if (halves !== exp_halves) begin
      fails++; $display("FAIL ratio%0d_wave: got %h expected %h", n, halves, exp_halves);
    end
    tests++;
    if (tk_cnt !== 2) begin fails++; $display("FAIL ratio%0d_ticks: got %0d expected 2", n, tk_cnt); end
  endtask

  task automatic test_change_mid_period();
    logic [11:0] ck, tk, rdy, nd;
    cfg_div = 8'd4; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tick === 1'b1 && cur_div === 8'd4) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd4)) begin
      fails++; $display("FAIL mid_setup: got cur_div %0d tick %b expected 4 and 1", cur_div, tick);
    end
    for (int i = 0; i < 12; i++) begin
      ck[i] = clk_out; tk[i] = tick; rdy[i] = cfg_ready; nd[i] = (cur_div === 8'd7);
      if (i == 0) begin cfg_div = 8'd7; cfg_valid = 1'b1; end
      if (i == 1) cfg_valid = 1'b0;
      step();
    end
    tests++;
    if (ck !== 12'h8F3) begin fails++; $display("FAIL mid_clk: got %h expected 8f3", ck); end
    tests++;
    if (tk !== 12'h811) begin fails++; $display("FAIL mid_tick: got %h expected 811", tk); end
    tests++;
    if (rdy !== 12'hFF9) begin fails++; $display("FAIL mid_ready: got %h expected ff9", rdy); end
    tests++;
    if (nd !== 12'hFF8) begin fails++; $display("FAIL mid_cur_div7: got %h expected ff8", nd); end
  endtask

  task automatic test_stop_start();
    logic [7:0] ck, rn, tk;
    cfg_div = 8'd6; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tick === 1'b1 && cur_div === 8'd6) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd6)) begin
      fails++; $display("FAIL stop_setup: got cur_div %0d tick %b expected 6 and 1", cur_div, tick);
    end
    for (int i = 0; i < 8; i++) begin
      ck[i] = clk_out; rn[i] = running; tk[i] = tick;
      if (i == 1) en = 1'b0;
      step();
    end
    tests++;
    if (ck !== 8'h07) begin fails++; $display("FAIL stop_clk: got %h expected 07", ck); end
    tests++;
    if (rn !== 8'h1F) begin fails++; $display("FAIL stop_running: got %h expected 1f", rn); end
    tests++;
    if (tk !== 8'h01) begin fails++; $display("FAIL stop_tick: got %h expected 01", tk); end
    en = 1'b1;
    step();
    tests++;
    if ({running, tick} !== 2'b10) begin fails++; $display("FAIL restart_first: got %b expected 10", {running, tick}); end
    step();
    tests++;
    if ({tick, clk_out} !== 2'b11) begin fails++; $display("FAIL restart_tick: got %b expected 11", {tick, clk_out}); end
  endtask

  task automatic test_clamp_and_max();
    int hc, lc, tc;
    cfg_div = 8'd0; cfg_valid = 1'b1;
    #1;
    tests++;
    if (cfg_err !== 1'b1) begin fails++; $display("FAIL clamp0_err: got %b expected 1", cfg_err); end
    step();
    cfg_valid = 1'b0;
    #1;
    tests++;
    if ({cfg_err, cfg_ready} !== 2'b00) begin fails++; $display("FAIL clamp0_after: got %b expected 00", {cfg_err, cfg_ready}); end
    for (int k = 0; k < 20; k++) begin
      if (tick === 1'b1 && cur_div === 8'd2) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd2)) begin
      fails++; $display("FAIL clamp0_div: got cur_div %0d tick %b expected 2 and 1", cur_div, tick);
    end
    cfg_div = 8'd255; cfg_valid = 1'b1;
    #1;
    tests++;
    if (cfg_err !== 1'b0) begin fails++; $display("FAIL max_err: got %b expected 0", cfg_err); end
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tick === 1'b1 && cur_div === 8'd255) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd255)) begin
      fails++; $display("FAIL max_apply: got cur_div %0d tick %b expected 255 and 1", cur_div, tick);
    end
    hc = 0; lc = 0; tc = 0;
    for (int i = 0; i < 255; i++) begin
      hc += int'(clk_out);
      tc += int'(tick);
      @(negedge clk); #1;
      lc += int'(clk_out);
      step();
    end
    tests++;
    if ({hc, lc, tc} !== {32'd128, 32'd127, 32'd1}) begin
      fails++; $display("FAIL max_wave: got high %0d low %0d ticks %0d expected 128 127 1", hc, lc, tc);
    end
    tests++;
    if (tick !== 1'b1) begin fails++; $display("FAIL max_period_end: got tick %b expected 1", tick); end
    cfg_div = 8'd1; cfg_valid = 1'b1;
    #1;
    tests++;
    if (cfg_err !== 1'b1) begin fails++; $display("FAIL clamp1_err: got %b expected 1", cfg_err); end
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (tick === 1'b1 && cur_div === 8'd2) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd2)) begin
      fails++; $display("FAIL clamp1_div: got cur_div %0d tick %b expected 2 and 1", cur_div, tick);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [9:0] halves;
    duty_mode = 1'b1; cfg_div = 8'd5; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tick === 1'b1 && cur_div === 8'd5) break;
      step();
    end
    tests++;
    if (!(tick === 1'b1 && cur_div === 8'd5)) begin
      fails++; $display("FAIL pulse_apply: got cur_div %0d tick %b expected 5 and 1", cur_div, tick);
    end
    for (int i = 0; i < 5; i++) begin
      halves[2*i] = clk_out;
      @(negedge clk); #1;
      halves[2*i+1] = clk_out;
      step();
    end
    tests++;
    if (halves !== 10'h003) begin fails++; $display("FAIL pulse_wave: got %h expected 003", halves); end
    cfg_div = 8'd9; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    tests++;
    if (cfg_ready !== 1'b0) begin fails++; $display("FAIL pulse_pending: got ready %b expected 0", cfg_ready); end
    rst = 1'b1; en = 1'b0;
    step();
    tests++;
    if ({cfg_ready, cfg_err, running, tick, clk_out, cur_div} !== {5'b10000, 8'd4}) begin
      fails++;
      $display("FAIL midreset_state: got %h expected %h",
               {cfg_ready, cfg_err, running, tick, clk_out, cur_div}, {5'b10000, 8'd4});
    end
    @(negedge clk); #1;
    tests++;
    if (clk_out !== 1'b0) begin fails++; $display("FAIL midreset_clk_low_phase: got %b expected 0", clk_out); end
    step();
    rst = 1'b0; duty_mode = 1'b0;
    repeat (3) step();
    tests++;
    if ({cur_div, cfg_ready, running} !== {8'd4, 2'b10}) begin
      fails++; $display("FAIL pending_dropped: got %h expected %h", {cur_div, cfg_ready, running}, {8'd4, 2'b10});
    end
    en = 1'b1;
    step();
    step();
    tests++;
    if ({tick, clk_out, cur_div} !== {2'b11, 8'd4}) begin
      fails++; $display("FAIL post_reset_start: got %h expected %h", {tick, clk_out, cur_div}, {2'b11, 8'd4});
    end
  endtask

  initial begin
    test_reset();
    test_even_default();
    test_ratio(5, 32'h0000_7C1F);
    test_ratio(3, 32'h0000_01C7);
    test_ratio(2, 32'h0000_0033);
    test_change_mid_period();
    test_stop_start();
    test_clamp_and_max();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
